// File: rtl/pipe_control_unit.sv
// Decode-stage control unit: registered ID/EX controls, load-use interlock,
// flush handling and a saturating illegal-instruction counter.
module pipe_control_unit #(
  parameter int LOAD_USE_STALL   = 1,
  parameter bit ENABLE_INTERLOCK = 1'b1,
  parameter int CNT_W            = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InstrValid,
  input  logic [31:0]      Instruction,
  input  logic             Flush,
  output logic             InstrReady,
  output logic             Stall,
  output logic             ExValid,
  output logic             RegDst,
  output logic             RegWriteEnable,
  output logic             ALUSrc,
  output logic             MemoryRE,
  output logic             MemoryWE,
  output logic             MemoryToReg,
  output logic [5:0]       ALUFunction,
  output logic [4:0]       ExWriteReg,
  output logic             IllegalInstr,
  output logic [CNT_W-1:0] IllegalCount
);

  localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_shamt;

  assign op           = Instruction[31:26];
  assign rs           = Instruction[25:21];
  assign rt           = Instruction[20:16];
  assign rd           = Instruction[15:11];
  assign unused_shamt = ^Instruction[10:6];

  logic is_nop;
  logic is_r;
  logic is_imm;
  logic is_load;
  logic is_store;
  logic legal;
  logic illegal;

  assign is_nop   = (Instruction == 32'd0);
  assign is_r     = (op == 6'd0) && !is_nop;
  assign is_imm   = (op[5:3] == 3'b001) && (op[2:0] != 3'b111);
  assign is_load  = (op[5:3] == 3'b100);
  assign is_store = (op[5:3] == 3'b101);
  assign legal    = is_r | is_imm | is_load | is_store;
  assign illegal  = !is_nop && !legal;

  logic       d_rdst;
  logic       d_rwe;
  logic       d_src;
  logic       d_mre;
  logic       d_mwe;
  logic       d_mtr;
  logic [5:0] d_fn;
  logic [4:0] d_wr;

  always_comb begin
    d_rdst = 1'b0;
    d_rwe  = 1'b0;
    d_src  = 1'b0;
    d_mre  = 1'b0;
    d_mwe  = 1'b0;
    d_mtr  = 1'b0;
    d_fn   = 6'd0;
    unique case (1'b1)
      is_r: begin
        d_rdst = 1'b1;
        d_rwe  = 1'b1;
        d_fn   = Instruction[5:0];
      end
      is_imm: begin
        d_rwe = 1'b1;
        d_src = 1'b1;
        case (op[2:0])
          3'b000:  d_fn = 6'b100000;
          3'b001:  d_fn = 6'b100001;
          3'b010:  d_fn = 6'b101010;
          3'b011:  d_fn = 6'b101011;
          3'b100:  d_fn = 6'b100100;
          3'b101:  d_fn = 6'b100101;
          3'b110:  d_fn = 6'b100110;
          default: d_fn = 6'd0;
        endcase
      end
      is_load: begin
        d_rwe = 1'b1;
        d_src = 1'b1;
        d_mre = 1'b1;
        d_mtr = 1'b1;
        d_fn  = 6'b100000;
      end
      is_store: begin
        d_src = 1'b1;
        d_mwe = 1'b1;
        d_fn  = 6'b100000;
      end
      default: ;
    endcase
    d_wr = d_rdst ? rd : rt;
  end

  logic [1:0] stall_cnt;
  logic       uses_rs;
  logic       uses_rt;
  logic       ex_load;
  logic       hazard;

  // rt is a source only for R-type and store; loads/immediates write it
  assign uses_rs = legal && (ExWriteReg == rs);
  assign uses_rt = (is_r | is_store) && (ExWriteReg == rt);
  assign ex_load = ExValid && MemoryRE && (ExWriteReg != 5'd0);
  assign hazard  = ENABLE_INTERLOCK && InstrValid
                && (stall_cnt == 2'd0) && ex_load
                && (uses_rs | uses_rt);

  assign InstrReady = !Reset
                   && (Flush || ((stall_cnt == 2'd0) && !hazard));
  assign Stall      = !Reset && InstrValid && !InstrReady;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ExValid        <= 1'b0;
      RegDst         <= 1'b0;
      RegWriteEnable <= 1'b0;
      ALUSrc         <= 1'b0;
      MemoryRE       <= 1'b0;
      MemoryWE       <= 1'b0;
      MemoryToReg    <= 1'b0;
      ALUFunction    <= 6'd0;
      ExWriteReg     <= 5'd0;
      IllegalInstr   <= 1'b0;
      IllegalCount   <= '0;
      stall_cnt      <= 2'd0;
    end else begin
      ExValid        <= 1'b0;
      RegDst         <= 1'b0;
      RegWriteEnable <= 1'b0;
      ALUSrc         <= 1'b0;
      MemoryRE       <= 1'b0;
      MemoryWE       <= 1'b0;
      MemoryToReg    <= 1'b0;
      ALUFunction    <= 6'd0;
      ExWriteReg     <= 5'd0;
      IllegalInstr   <= 1'b0;
      if (Flush) begin
        stall_cnt <= 2'd0;
      end else if (stall_cnt != 2'd0) begin
        stall_cnt <= stall_cnt - 2'd1;
      end else if (InstrValid) begin
        if (hazard) begin
          stall_cnt <= STALL_INIT;
        end else if (illegal) begin
          IllegalInstr <= 1'b1;
          if (IllegalCount != '1)
            IllegalCount <= IllegalCount + CNT_ONE;
        end else if (legal) begin
          ExValid        <= 1'b1;
          RegDst         <= d_rdst;
          RegWriteEnable <= d_rwe;
          ALUSrc         <= d_src;
          MemoryRE       <= d_mre;
          MemoryWE       <= d_mwe;
          MemoryToReg    <= d_mtr;
          ALUFunction    <= d_fn;
          ExWriteReg     <= d_wr;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: three configurations driven in lockstep,
// checked against a rule-level reference model plus directed vectors.
module tb_pipe_control_unit;

  typedef struct packed {
    logic       v;
    logic       rdst;
    logic       rwe;
    logic       src;
    logic       mre;
    logic       mwe;
    logic       mtr;
    logic [5:0] fn;
    logic [4:0] wr;
  } ctl_t;

  typedef struct {
    logic [31:0] w;
    ctl_t        c;
    logic        ill;
  } vec_t;

  localparam int LS [3] = '{1, 3, 1};
  localparam int IL [3] = '{1, 1, 0};
  localparam int CMAX [3] = '{255, 3, 255};
  localparam logic [5:0] IMM_FN [8] =
    '{6'h20, 6'h21, 6'h2A, 6'h2B, 6'h24, 6'h25, 6'h26, 6'h00};

  localparam logic [31:0] ADDI = 32'h20010005;
  localparam logic [31:0] ORI  = 32'h342200FF;
  localparam logic [31:0] LW   = 32'h8C080004;
  localparam logic [31:0] ADD  = 32'h01084820;
  localparam logic [31:0] LW0  = 32'h8C000004;
  localparam logic [31:0] ADD0 = 32'h00004820;
  localparam logic [31:0] ILL  = 32'h08000000;
  localparam logic [31:0] SW   = 32'hAD280000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr = 32'd0;

  logic       ready [3];
  logic       stall [3];
  logic       ev [3];
  logic       rdst [3];
  logic       rwe [3];
  logic       src [3];
  logic       mre [3];
  logic       mwe [3];
  logic       mtr [3];
  logic       pulse [3];
  logic [5:0] fn [3];
  logic [4:0] wr [3];
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [7:0] cnt2;

  pipe_control_unit #(.LOAD_USE_STALL(1), .ENABLE_INTERLOCK(1'b1), .CNT_W(8)) u0 (
    .Clock(clk), .Reset(rst), .InstrValid(valid), .Instruction(instr),
    .Flush(flush), .InstrReady(ready[0]), .Stall(stall[0]), .ExValid(ev[0]),
    .RegDst(rdst[0]), .RegWriteEnable(rwe[0]), .ALUSrc(src[0]),
    .MemoryRE(mre[0]), .MemoryWE(mwe[0]), .MemoryToReg(mtr[0]),
    .ALUFunction(fn[0]), .ExWriteReg(wr[0]), .IllegalInstr(pulse[0]),
    .IllegalCount(cnt0));

  pipe_control_unit #(.LOAD_USE_STALL(3), .ENABLE_INTERLOCK(1'b1), .CNT_W(2)) u1 (
    .Clock(clk), .Reset(rst), .InstrValid(valid), .Instruction(instr),
    .Flush(flush), .InstrReady(ready[1]), .Stall(stall[1]), .ExValid(ev[1]),
    .RegDst(rdst[1]), .RegWriteEnable(rwe[1]), .ALUSrc(src[1]),
    .MemoryRE(mre[1]), .MemoryWE(mwe[1]), .MemoryToReg(mtr[1]),
    .ALUFunction(fn[1]), .ExWriteReg(wr[1]), .IllegalInstr(pulse[1]),
    .IllegalCount(cnt1));

  pipe_control_unit #(.LOAD_USE_STALL(1), .ENABLE_INTERLOCK(1'b0), .CNT_W(8)) u2 (
    .Clock(clk), .Reset(rst), .InstrValid(valid), .Instruction(instr),
    .Flush(flush), .InstrReady(ready[2]), .Stall(stall[2]), .ExValid(ev[2]),
    .RegDst(rdst[2]), .RegWriteEnable(rwe[2]), .ALUSrc(src[2]),
    .MemoryRE(mre[2]), .MemoryWE(mwe[2]), .MemoryToReg(mtr[2]),
    .ALUFunction(fn[2]), .ExWriteReg(wr[2]), .IllegalInstr(pulse[2]),
    .IllegalCount(cnt2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%h required=%h t=%0t",
               nm, i, act, exp, $time);
    end
  endtask

  function automatic ctl_t dut_ctl(input int i);
    return {ev[i], rdst[i], rwe[i], src[i], mre[i], mwe[i], mtr[i],
            fn[i], wr[i]};
  endfunction

  function automatic logic [31:0] dut_cnt(input int i);
    case (i)
      0:       return 32'(cnt0);
      1:       return 32'(cnt1);
      default: return 32'(cnt2);
    endcase
  endfunction

  function automatic ctl_t mk(input logic v, rd, we, sr, re, mw, mt,
                              input logic [5:0] f, input logic [4:0] r);
    return {v, rd, we, sr, re, mw, mt, f, r};
  endfunction

  // Reference model: decode straight from the opcode groups
  ctl_t m_ex [3];
  bit   m_pulse [3];
  int   m_cnt [3];
  int   m_left [3];

  function automatic ctl_t m_decode(input logic [31:0] w, output bit ill);
    ctl_t c;
    int   grp;
    int   sub;
    c   = '0;
    ill = 1'b0;
    grp = int'(w[31:29]);
    sub = int'(w[28:26]);
    if (w == 32'd0) return c;
    if (w[31:26] == 6'd0) begin
      c = mk(1, 1, 1, 0, 0, 0, 0, w[5:0], w[15:11]);
    end else if (grp == 1 && sub != 7) begin
      c = mk(1, 0, 1, 1, 0, 0, 0, IMM_FN[sub], w[20:16]);
    end else if (grp == 4) begin
      c = mk(1, 0, 1, 1, 1, 0, 1, 6'h20, w[20:16]);
    end else if (grp == 5) begin
      c = mk(1, 0, 0, 1, 0, 1, 0, 6'h20, w[20:16]);
    end else begin
      ill = 1'b1;
    end
    return c;
  endfunction

  function automatic bit m_reads(input logic [31:0] w, input logic [4:0] r);
    bit   ill;
    ctl_t c;
    c = m_decode(w, ill);
    if (w == 32'd0 || ill) return 1'b0;
    if (w[25:21] == r) return 1'b1;
    if ((w[31:26] == 6'd0 || w[31:29] == 3'd5) && w[20:16] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_hazard(input int i, input logic v,
                                  input logic [31:0] w);
    return IL[i] != 0 && v && m_left[i] == 0 && m_ex[i].v && m_ex[i].mre
        && m_ex[i].wr != 5'd0 && m_reads(w, m_ex[i].wr);
  endfunction

  function automatic bit m_ready(input int i, input logic r, input logic v,
                                 input logic [31:0] w, input logic f);
    if (r) return 1'b0;
    if (f) return 1'b1;
    if (m_left[i] > 0) return 1'b0;
    return !m_hazard(i, v, w);
  endfunction

  task automatic m_update(input int i, input logic r, input logic v,
                          input logic [31:0] w, input logic f);
    bit   ill;
    bit   hz;
    ctl_t c;
    hz         = m_hazard(i, v, w);
    m_pulse[i] = 1'b0;
    m_ex[i]    = '0;
    if (r) begin
      m_cnt[i]  = 0;
      m_left[i] = 0;
    end else if (f) begin
      m_left[i] = 0;
    end else if (m_left[i] > 0) begin
      m_left[i]--;
    end else if (v) begin
      if (hz) begin
        m_left[i] = LS[i] - 1;
      end else begin
        c = m_decode(w, ill);
        if (ill) begin
          m_pulse[i] = 1'b1;
          if (m_cnt[i] < CMAX[i]) m_cnt[i]++;
        end else begin
          m_ex[i] = c;
        end
      end
    end
  endtask

  logic last_ready [3];
  logic last_stall [3];

  task automatic peek(input logic v, input logic [31:0] w,
                      input logic f, input logic r);
    rst = r; valid = v; instr = w; flush = f;
    #2;
  endtask

  task automatic step(input logic v, input logic [31:0] w,
                      input logic f, input logic r);
    rst = r; valid = v; instr = w; flush = f;
    #2;
    for (int i = 0; i < 3; i++) begin
      last_ready[i] = ready[i];
      last_stall[i] = stall[i];
      chk("ready", i, 32'(ready[i]), 32'(m_ready(i, r, v, w, f)));
      chk("stall", i, 32'(stall[i]),
          32'(!r && v && !m_ready(i, r, v, w, f)));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) m_update(i, r, v, w, f);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("ctrl", i, 32'(dut_ctl(i)), 32'(m_ex[i]));
      chk("pulse", i, 32'(pulse[i]), 32'(m_pulse[i]));
      chk("count", i, dut_cnt(i), 32'(m_cnt[i]));
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  c;
    int          k;
    w = $urandom;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    k = $urandom_range(0, 5);
    case (k)
      0: w = 32'd0;
      1: w = {6'd0, a, b, c, 5'd0, 6'($urandom)};
      2: w = {3'b001, 3'($urandom), a, b, 16'($urandom)};
      3: w = {3'b100, 3'($urandom), a, b, 16'($urandom)};
      4: w = {3'b101, 3'($urandom), a, b, 16'($urandom)};
      default: ;
    endcase
    return w;
  endfunction

  vec_t tbl [16];
  int   sc [3];
  int   bub [3];

  initial begin
    tbl[0]  = '{ADDI,         mk(1,0,1,1,0,0,0,6'h20,5'd1), 1'b0};
    tbl[1]  = '{ORI,          mk(1,0,1,1,0,0,0,6'h25,5'd2), 1'b0};
    tbl[2]  = '{ADD,          mk(1,1,1,0,0,0,0,6'h20,5'd9), 1'b0};
    tbl[3]  = '{LW,           mk(1,0,1,1,1,0,1,6'h20,5'd8), 1'b0};
    tbl[4]  = '{SW,           mk(1,0,0,1,0,1,0,6'h20,5'd8), 1'b0};
    tbl[5]  = '{32'h00000000, mk(0,0,0,0,0,0,0,6'h00,5'd0), 1'b0};
    tbl[6]  = '{ILL,          mk(0,0,0,0,0,0,0,6'h00,5'd0), 1'b1};
    tbl[7]  = '{32'h3C000000, mk(0,0,0,0,0,0,0,6'h00,5'd0), 1'b1};
    tbl[8]  = '{32'h28A3FFFF, mk(1,0,1,1,0,0,0,6'h2A,5'd3), 1'b0};
    tbl[9]  = '{32'h2CE40001, mk(1,0,1,1,0,0,0,6'h2B,5'd4), 1'b0};
    tbl[10] = '{32'h30000000, mk(1,0,1,1,0,0,0,6'h24,5'd0), 1'b0};
    tbl[11] = '{32'h38C7000F, mk(1,0,1,1,0,0,0,6'h26,5'd7), 1'b0};
    tbl[12] = '{32'h8000002A, mk(1,0,1,1,1,0,1,6'h20,5'd0), 1'b0};
    tbl[13] = '{32'h0062282A, mk(1,1,1,0,0,0,0,6'h2A,5'd5), 1'b0};
    tbl[14] = '{32'hC0000000, mk(0,0,0,0,0,0,0,6'h00,5'd0), 1'b1};
    tbl[15] = '{32'h24000000, mk(1,0,1,1,0,0,0,6'h21,5'd0), 1'b0};

    for (int i = 0; i < 3; i++) begin
      m_ex[i] = '0; m_pulse[i] = 0; m_cnt[i] = 0; m_left[i] = 0;
    end

    // reset state and first accepted instructions
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    peek(1, ADDI, 0, 1);
    chk("ready_in_rst", 0, 32'(ready[0]), 0);
    chk("stall_in_rst", 0, 32'(stall[0]), 0);
    for (int i = 0; i < 3; i++) chk("rst_ctrl", i, 32'(dut_ctl(i)), 0);
    peek(1, ADDI, 0, 0);
    chk("ready_after_rst", 0, 32'(ready[0]), 1);
    step(1, ADDI, 0, 0);
    chk("addi_ctrl", 0, 32'(dut_ctl(0)), 32'(mk(1,0,1,1,0,0,0,6'h20,5'd1)));
    step(1, ORI, 0, 0);
    chk("ori_fn", 0, 32'(fn[0]), 32'h25);
    chk("ori_wr", 0, 32'(wr[0]), 32'd2);

    // decode table
    foreach (tbl[k]) begin
      step(0, 0, 0, 0);
      step(1, tbl[k].w, 0, 0);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("tbl%0d_ctrl", k), i, 32'(dut_ctl(i)), 32'(tbl[k].c));
        chk($sformatf("tbl%0d_ill", k), i, 32'(pulse[i]), 32'(tbl[k].ill));
      end
    end

    // load-use hazard: 1 bubble, 3 bubbles, none without interlock
    step(0, 0, 0, 0);
    step(1, LW, 0, 0);
    for (int i = 0; i < 3; i++) begin sc[i] = 0; bub[i] = 0; end
    for (int k = 0; k < 5; k++) begin
      step(1, ADD, 0, 0);
      for (int i = 0; i < 3; i++) begin
        sc[i]  += int'(last_stall[i]);
        bub[i] += int'(!ev[i]);
      end
    end
    chk("lu_stalls", 0, 32'(sc[0]), 1);
    chk("lu_stalls", 1, 32'(sc[1]), 3);
    chk("lu_stalls", 2, 32'(sc[2]), 0);
    chk("lu_bubbles", 0, 32'(bub[0]), 1);
    chk("lu_bubbles", 1, 32'(bub[1]), 3);
    chk("lu_bubbles", 2, 32'(bub[2]), 0);
    chk("lu_add", 0, 32'(dut_ctl(0)), 32'(mk(1,1,1,0,0,0,0,6'h20,5'd9)));

    // load to $0 never stalls
    step(0, 0, 0, 0);
    step(1, LW0, 0, 0);
    step(1, ADD0, 0, 0);
    chk("lw0_stall", 0, 32'(last_stall[0]), 0);
    chk("lw0_stall", 1, 32'(last_stall[1]), 0);

    // illegal counter saturation (CNT_W=2 on instance 1)
    step(0, 0, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      step(1, ILL, 0, 0);
      chk("ill_pulse", 1, 32'(pulse[1]), 1);
      chk("ill_cnt", 1, 32'(cnt1), 32'(k > 3 ? 3 : k));
    end

    // flush during a stall in progress
    step(0, 0, 0, 0);
    step(1, LW, 0, 0);
    step(1, ADD, 0, 0);
    step(1, ADD, 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk("flush_ready", i, 32'(last_ready[i]), 1);
      chk("flush_bubble", i, 32'(ev[i]), 0);
    end
    peek(1, ADD, 0, 0);
    chk("post_flush_ready", 1, 32'(ready[1]), 1);
    step(1, ADD, 0, 0);

    // flush together with a hazard, then with an illegal word
    step(0, 0, 0, 0);
    step(1, LW, 0, 0);
    step(1, ADD, 1, 0);
    for (int i = 0; i < 3; i++)
      chk("flush_hz_stall", i, 32'(last_stall[i]), 0);
    step(1, ILL, 1, 0);
    for (int i = 0; i < 3; i++) chk("flush_ill", i, 32'(pulse[i]), 0);
    chk("flush_ill_cnt", 0, 32'(cnt0), 32'd4);
    chk("flush_ill_cnt", 1, 32'(cnt1), 32'd3);

    // store, then reset mid-stall
    step(0, 0, 0, 0);
    step(1, SW, 0, 0);
    chk("sw_mwe", 0, 32'(mwe[0]), 1);
    chk("sw_rwe", 0, 32'(rwe[0]), 0);
    chk("sw_src", 0, 32'(src[0]), 1);
    step(1, LW, 0, 0);
    step(1, ADD, 0, 0);
    step(1, ADD, 0, 1);
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_ctrl", i, 32'(dut_ctl(i)), 0);
      chk("mid_rst_cnt", i, dut_cnt(i), 0);
    end
    step(1, ADD, 0, 0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(logic'($urandom_range(0, 3) != 0), rnd_instr(),
           logic'($urandom_range(0, 15) == 0),
           logic'($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_control_unit.md
# pipe_control_unit

Registered decode-stage control unit for the 4-stage pipeline. It decodes one 32-bit instruction per cycle into ID/EX control signals, held in an output register. It also detects load-use hazards against the instruction currently in EX, inserting a configurable number of bubbles, and supports flush, illegal-opcode detection and a saturating illegal-instruction counter. It sits between instruction fetch (valid/ready handshake) and the EX-stage ALU/memory datapath.

## Interface
- LOAD_USE_STALL, 1: bubbles inserted per load-use hazard; legal range 1..3.
- ENABLE_INTERLOCK, 1: 1 = hazard detection active; 0 = never stall (software-scheduled code).
- CNT_W, 8: width of IllegalCount.

Ports:
- Clock  in  1  sole clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high.
- InstrValid  in  1  Instruction is valid this cycle.
- Instruction  in  32  instruction word in decode.
- Flush  in  1  kill the decode-stage instruction this cycle.
- InstrReady  out  1  combinational; instruction consumed when InstrValid && InstrReady.
- Stall  out  1  combinational; equals InstrValid && !InstrReady outside reset.
- ExValid  out  1  registered; EX register holds a real instruction.
- RegDst, RegWriteEnable, ALUSrc, MemoryRE, MemoryWE, MemoryToReg  out  1 each  registered controls.
- ALUFunction  out  6  registered ALU function code.
- ExWriteReg  out  5  registered destination: rd when RegDst=1, else rt.
- IllegalInstr  out  1  registered one-cycle pulse.
- IllegalCount  out  CNT_W  saturating count of illegal instructions.

## Operation
- Decode table (opcode = Instruction[31:26]):
  - all-zero word: NOP; bubble, ExValid=0.
  - 000000: R-type; RegDst=1, RegWriteEnable=1, ALUSrc=0, ALUFunction=Instruction[5:0].
  - 001xxx: immediate; RegWriteEnable=1, ALUSrc=1. Instruction[28:26] sets ALUFunction: 000→100000, 001→100001, 010→101010, 011→101011, 100→100100, 101→100101, 110→100110. Value 111 is illegal.
  - 100xxx: load; RegWriteEnable=1, ALUSrc=1, ALUFunction=100000, MemoryRE=1, MemoryToReg=1.
  - 101xxx: store; ALUSrc=1, ALUFunction=100000, MemoryWE=1.
  - anything else: illegal.
- Bubble: every registered control, ExWriteReg and ExValid are 0.
- Illegal instruction:
  - consumed and replaced by a bubble.
  - IllegalInstr=1 for one cycle.
  - IllegalCount increments and saturates at 2^CNT_W−1.
- Hazard (ENABLE_INTERLOCK=1), evaluated only when InstrValid=1 and StallCnt=0. A hazard exists when all hold:
  - ExValid and MemoryRE are 1, and ExWriteReg≠0;
  - ExWriteReg equals rs of any legal non-NOP instruction, or equals rt of an R-type or store.
- Stall counter StallCnt (2 bits):
  - On a hazard: InstrReady=0, a bubble is registered, StallCnt←LOAD_USE_STALL−1.
  - While StallCnt>0: InstrReady=0, a bubble is registered, StallCnt decrements.
  - The instruction is accepted once StallCnt=0 and no hazard remains, giving exactly LOAD_USE_STALL bubbles.
- InstrValid=0: bubble registered, StallCnt still decrements.
- Priority: Reset > Flush > stall > decode.
  - Flush registers a bubble, clears StallCnt, does not count an illegal instruction and holds InstrReady=1.
  - The flushed instruction counts as consumed.

## Timing
- Reset values:
  - all registered outputs 0, IllegalCount=0, StallCnt=0.
  - InstrReady=0 and Stall=0 while Reset is high.
  - InstrReady=1 on the first cycle after Reset deasserts.
- Latency: an instruction accepted in cycle N has its controls visible from cycle N+1 until the next edge.
- IllegalInstr is aligned with the bubble slot (cycle N+1).
- Reset asserted mid-stall clears StallCnt; the pending instruction is re-presented by fetch.
- Flush and hazard in the same cycle: flush wins, no stall.
- Illegal and Flush in the same cycle: no pulse, no count.

## Test plan
- Reset, then 0x20010005 (addi) → next cycle ExValid=1, RegWriteEnable=1, ALUSrc=1, ALUFunction=100000, ExWriteReg=1. Then 0x342200FF (ori) → ALUFunction=100101, ExWriteReg=2.
- 0x8C080004 (lw rt=8) followed by 0x01084820 (add 9,8,8), LOAD_USE_STALL=1:
  - Stall=1 for one cycle, then one bubble.
  - add accepted next cycle with RegDst=1, ALUFunction=100000, ExWriteReg=9.
  - Repeat with LOAD_USE_STALL=3 → three bubbles.
- lw to $0 (0x8C000004) followed by an add reading $0 → no stall. Same hazard pair with ENABLE_INTERLOCK=0 → no stall.
- 0x08000000 ×3 with CNT_W=2 → three IllegalInstr pulses, IllegalCount 1,2,3. A fourth illegal word keeps IllegalCount at 3.
- Hazard stall in progress plus Flush → next cycle StallCnt=0, bubble registered, InstrReady=1. Illegal word plus Flush → no IllegalInstr pulse.
- 0xAD280000 (sw) → MemoryWE=1, RegWriteEnable=0, ALUSrc=1. Reset asserted mid-stream → all outputs 0 next cycle.
